// File: rtl/ms_tmr_pkg.sv
// Shared types and default widths for the N-channel timer/PWM (ms_tmrn_cc) and its capture unit.
package ms_tmr_pkg;

  localparam int unsigned DEF_W    = 32;
  localparam int unsigned DEF_N_CH = 4;
  localparam int unsigned DEF_PS_W = 8;

  // Encoding 2'b11 is not listed and decodes as up-count.
  typedef enum logic [1:0] {
    TMR_UP     = 2'b00,
    TMR_DOWN   = 2'b01,
    TMR_UPDOWN = 2'b10
  } tmr_mode_e;

  typedef enum logic [1:0] {
    CP_NONE = 2'b00,
    CP_RISE = 2'b01,
    CP_FALL = 2'b10,
    CP_BOTH = 2'b11
  } cp_event_e;

  typedef enum logic [1:0] {
    RUN_IDLE   = 2'b00,
    RUN_ACTIVE = 2'b01,
    RUN_HALT   = 2'b10
  } run_state_e;

endpackage

// File: rtl/ms_tmr_capture.sv
// Input capture: 2-flop synchroniser on ctr_in, edge select, saturating interval counter.
module ms_tmr_capture
  import ms_tmr_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ctr_in,
  input  logic         cp_en,
  input  logic [1:0]   cp_event,
  output logic [W-1:0] cp_count,
  output logic         cp_flag
);

  localparam logic [W-1:0] ONE = W'(1);

  logic         sync1, sync2, sync3;
  logic         cp_en_q;
  logic [W-1:0] cap_ctr;
  logic [W-1:0] cap_inc;
  logic         rise, fall, evt;

  assign rise    = sync2 & ~sync3;
  assign fall    = ~sync2 & sync3;
  assign cap_inc = (cap_ctr == '1) ? cap_ctr : cap_ctr + ONE;

  always_comb begin
    evt = 1'b0;
    case (cp_event)
      CP_RISE: evt = rise;
      CP_FALL: evt = fall;
      CP_BOTH: evt = rise | fall;
      default: evt = 1'b0;
    endcase
  end

  // The reported interval includes the event clock itself, so it equals the clk count between edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      cp_en_q  <= 1'b0;
      cap_ctr  <= '0;
      cp_count <= '0;
      cp_flag  <= 1'b0;
    end else if (!en) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      cp_en_q  <= 1'b0;
      cap_ctr  <= '0;
      cp_count <= '0;
      cp_flag  <= 1'b0;
    end else begin
      sync1   <= ctr_in;
      sync2   <= sync1;
      sync3   <= sync2;
      cp_en_q <= cp_en;
      cp_flag <= 1'b0;
      if (!cp_en || !cp_en_q) begin
        cap_ctr <= '0;
      end else if (evt) begin
        cp_count <= cap_inc;
        cap_ctr  <= '0;
        cp_flag  <= 1'b1;
      end else begin
        cap_ctr <= cap_inc;
      end
    end
  end

endmodule

// File: rtl/ms_tmrn_cc.sv
// N-channel timer/PWM with prescaler, up/down/up-down modes and input capture.
// Optional MS_TMRN_SHADOW_EN: period/cmp shadowed on start and on every timeout.
module ms_tmrn_cc
  import ms_tmr_pkg::*;
#(
  parameter int unsigned W    = DEF_W,
  parameter int unsigned N_CH = DEF_N_CH,
  parameter int unsigned PS_W = DEF_PS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tmr_en,
  input  logic [1:0]        mode,
  input  logic              one_shot,
  input  logic [PS_W-1:0]   prescale,
  input  logic [W-1:0]      period,
  input  logic [N_CH*W-1:0] cmp,
  input  logic [N_CH-1:0]   pwm_en,
  input  logic [N_CH-1:0]   pwm_pol,
  input  logic              ctr_in,
  input  logic              cp_en,
  input  logic [1:0]        cp_event,
  output logic [W-1:0]      tmr,
  output logic [W-1:0]      cp_count,
  output logic [N_CH-1:0]   pwm_out,
  output logic              to_flag,
  output logic [N_CH-1:0]   match_flag,
  output logic              cp_flag
);

  localparam logic [W-1:0]    ONE    = W'(1);
  localparam logic [PS_W-1:0] PS_ONE = PS_W'(1);

  run_state_e        state, state_nxt;
  logic              running;
  logic              tmr_en_q;
  logic              tmr_en_rise;
  logic [PS_W-1:0]   ps_cnt;
  logic              tick;
  logic              dir_dn;
  logic [W-1:0]      tmr_nxt;
  logic              dir_nxt;
  logic              timeout;
  logic [W-1:0]      per_use;
  logic [N_CH*W-1:0] cmp_use;
  logic [N_CH-1:0]   pwm_d;
  logic [N_CH-1:0]   match_d;

  assign tmr_en_rise = tmr_en & ~tmr_en_q;
  assign tick        = running && (ps_cnt == prescale);

`ifdef MS_TMRN_SHADOW_EN
  logic [W-1:0]      per_sh;
  logic [N_CH*W-1:0] cmp_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_sh <= '0;
      cmp_sh <= '0;
    end else if (!en) begin
      per_sh <= '0;
      cmp_sh <= '0;
    end else if (tmr_en_rise || (tick && timeout)) begin
      per_sh <= period;
      cmp_sh <= cmp;
    end
  end

  assign per_use = per_sh;
  assign cmp_use = cmp_sh;
`else
  assign per_use = period;
  assign cmp_use = cmp;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN_IDLE;
    end else if (!en) begin
      state <= RUN_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN_IDLE:   if (tmr_en_rise) state_nxt = RUN_ACTIVE;
      RUN_ACTIVE: begin
        if (!tmr_en) state_nxt = RUN_IDLE;
        else if (tick && timeout && one_shot) state_nxt = RUN_HALT;
      end
      RUN_HALT:   if (!tmr_en) state_nxt = RUN_IDLE;
      default:    state_nxt = RUN_IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN_ACTIVE);
  end

  // Down reload always takes the live period; in shadow builds it is the value being latched.
  always_comb begin
    tmr_nxt = tmr;
    dir_nxt = dir_dn;
    timeout = 1'b0;
    case (mode)
      TMR_DOWN: begin
        if (tmr == '0) begin
          tmr_nxt = period;
          timeout = 1'b1;
        end else begin
          tmr_nxt = tmr - ONE;
        end
      end
      TMR_UPDOWN: begin
        if (per_use == '0) begin
          tmr_nxt = '0;
          dir_nxt = 1'b0;
          timeout = 1'b1;
        end else if (!dir_dn) begin
          if (tmr == per_use) begin
            tmr_nxt = tmr - ONE;
            dir_nxt = 1'b1;
          end else begin
            tmr_nxt = tmr + ONE;
            dir_nxt = ((tmr + ONE) == per_use);
          end
        end else if (tmr <= ONE) begin
          tmr_nxt = '0;
          dir_nxt = 1'b0;
          timeout = 1'b1;
        end else begin
          tmr_nxt = tmr - ONE;
        end
      end
      default: begin
        if (tmr == per_use) begin
          tmr_nxt = '0;
          timeout = 1'b1;
        end else begin
          tmr_nxt = tmr + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_en_q <= 1'b0;
      ps_cnt   <= '0;
      tmr      <= '0;
      dir_dn   <= 1'b0;
      to_flag  <= 1'b0;
    end else if (!en) begin
      tmr_en_q <= 1'b0;
      ps_cnt   <= '0;
      tmr      <= '0;
      dir_dn   <= 1'b0;
      to_flag  <= 1'b0;
    end else begin
      tmr_en_q <= tmr_en;
      to_flag  <= tick & timeout;
      if (tmr_en_rise) begin
        ps_cnt <= '0;
        tmr    <= (mode == TMR_DOWN) ? period : '0;
        dir_dn <= 1'b0;
      end else if (running) begin
        ps_cnt <= tick ? '0 : ps_cnt + PS_ONE;
        if (tick) begin
          tmr    <= tmr_nxt;
          dir_dn <= dir_nxt;
        end
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W-1:0] cmp_i;
    assign cmp_i      = cmp_use[i*W +: W];
    assign pwm_d[i]   = pwm_en[i] ? ((tmr < cmp_i) ^ pwm_pol[i]) : pwm_pol[i];
    assign match_d[i] = tick & (tmr_nxt == cmp_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out    <= '0;
      match_flag <= '0;
    end else if (!en) begin
      pwm_out    <= pwm_pol;
      match_flag <= '0;
    end else begin
      pwm_out    <= pwm_d;
      match_flag <= match_d;
    end
  end

  ms_tmr_capture #(
    .W(W)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ctr_in   (ctr_in),
    .cp_en    (cp_en),
    .cp_event (cp_event),
    .cp_count (cp_count),
    .cp_flag  (cp_flag)
  );

endmodule

// File: tb/tb_ms_tmrn_cc.sv
// Directed self-checking bench for ms_tmrn_cc (default build, MS_TMRN_SHADOW_EN undefined).
`timescale 1ns/1ps
module tb_ms_tmrn_cc;

  localparam int unsigned W    = 8;
  localparam int unsigned N_CH = 4;
  localparam int unsigned PS_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              tmr_en;
  logic [1:0]        mode;
  logic              one_shot;
  logic [PS_W-1:0]   prescale;
  logic [W-1:0]      period;
  logic [N_CH*W-1:0] cmp;
  logic [N_CH-1:0]   pwm_en;
  logic [N_CH-1:0]   pwm_pol;
  logic              ctr_in;
  logic              cp_en;
  logic [1:0]        cp_event;
  logic [W-1:0]      tmr;
  logic [W-1:0]      cp_count;
  logic [N_CH-1:0]   pwm_out;
  logic              to_flag;
  logic [N_CH-1:0]   match_flag;
  logic              cp_flag;

  logic ctr_run  = 1'b0;
  logic ctr_auto = 1'b0;
  logic ctr_man  = 1'b0;
  assign ctr_in = ctr_run ? ctr_auto : ctr_man;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  // Free-running event source, phase-locked to the moment capture testing starts.
  initial begin
    wait (ctr_run);
    forever #939 ctr_auto = ~ctr_auto;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  ms_tmrn_cc #(
    .W    (W),
    .N_CH (N_CH),
    .PS_W (PS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .tmr_en     (tmr_en),
    .mode       (mode),
    .one_shot   (one_shot),
    .prescale   (prescale),
    .period     (period),
    .cmp        (cmp),
    .pwm_en     (pwm_en),
    .pwm_pol    (pwm_pol),
    .ctr_in     (ctr_in),
    .cp_en      (cp_en),
    .cp_event   (cp_event),
    .tmr        (tmr),
    .cp_count   (cp_count),
    .pwm_out    (pwm_out),
    .to_flag    (to_flag),
    .match_flag (match_flag),
    .cp_flag    (cp_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    checks++;
    assert (int'(obs) >= lo && int'(obs) <= hi) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge right after the tmr_en rising-edge clock.
  task automatic restart();
    tmr_en = 1'b0;
    step(1);
    tmr_en = 1'b1;
    step(1);
  endtask

  task automatic wait_cp(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step(1);
      if (cp_flag) ok = 1'b1;
    end
  endtask

  initial begin
    int   cnt, first, second, h0, h1, h2, inv, m0, m0at, tcnt, tat0, maxt, zc;
    logic ok;

    rst = 1'b1; en = 1'b1; tmr_en = 1'b0; mode = 2'b00; one_shot = 1'b0;
    prescale = '0; period = '0; cmp = '0; pwm_en = '0; pwm_pol = '0;
    cp_en = 1'b0; cp_event = 2'b00;
    step(2);
    chk("rst_tmr", tmr, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_to", to_flag, 0);
    chk("rst_cp_count", cp_count, 0);
    rst = 1'b0;
    step(1);

    // 1: down, one-shot, period 20
    mode = 2'b01; one_shot = 1'b1; period = 8'd20; prescale = 8'd0;
    restart();
    chk("t1_load", tmr, 20);
    cnt = 0; first = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (i == 10) chk("t1_mid", tmr, 10);
      if (to_flag) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk("t1_to_cnt", cnt, 1);
    chk("t1_to_at", first, 21);
    chk("t1_hold", tmr, 20);
    restart();
    step(5);
    chk("t1_restart", tmr, 15);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (to_flag) cnt++;
    end
    chk("t1_restart_to", cnt, 1);

    // 2: up, periodic, period 10, prescale 3
    mode = 2'b00; one_shot = 1'b0; period = 8'd10; prescale = 8'd3;
    restart();
    cnt = 0; first = -1; second = -1;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (i == 3) chk("t2_pre_hold", tmr, 0);
      if (i == 4) chk("t2_first_tick", tmr, 1);
      if (i == 40) chk("t2_top", tmr, 10);
      if (i == 88) chk("t2_wrap2", tmr, 0);
      if (to_flag) begin
        cnt++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("t2_to_cnt", cnt, 2);
    chk("t2_to_first", first, 44);
    chk("t2_to_second", second, 88);

    // 3: PWM channels, up, period 9
    prescale = 8'd0; period = 8'd9;
    cmp = {8'd5, 8'd12, 8'd0, 8'd5};
    pwm_pol = 4'b1000; pwm_en = 4'hF;
    restart();
    step(2);
    h0 = 0; h1 = 0; h2 = 0; inv = 0; m0 = 0; m0at = 0; tcnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (pwm_out[0]) h0++;
      if (pwm_out[1]) h1++;
      if (pwm_out[2]) h2++;
      if (pwm_out[3] == ~pwm_out[0]) inv++;
      if (match_flag[0]) m0++;
      if (match_flag[0] && tmr == 8'd5) m0at++;
      if (to_flag) tcnt++;
    end
    chk("t3_ch0_high", h0, 20);
    chk("t3_ch1_cmp0", h1, 0);
    chk("t3_ch2_over", h2, 40);
    chk("t3_ch3_inv", inv, 40);
    chk("t3_match_cnt", m0, 4);
    chk("t3_match_at5", m0at, 4);
    chk("t3_to_cnt", tcnt, 4);

    // 4: up-down, period 8, cmp0 3
    mode = 2'b10; period = 8'd8; pwm_pol = 4'b0000;
    cmp = {8'd5, 8'd12, 8'd0, 8'd3};
    restart();
    step(2);
    m0 = 0; tcnt = 0; tat0 = 0; h0 = 0; maxt = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (match_flag[0]) m0++;
      if (to_flag) tcnt++;
      if (to_flag && tmr == 8'd0) tat0++;
      if (pwm_out[0]) h0++;
      if (int'(tmr) > maxt) maxt = int'(tmr);
    end
    chk("t4_match_cnt", m0, 8);
    chk("t4_to_cnt", tcnt, 4);
    chk("t4_to_valley", tat0, 4);
    chk("t4_pwm_high", h0, 20);
    chk("t4_peak", maxt, 8);

    // period 0: timeout on every tick, counter pinned at 0
    mode = 2'b00; period = 8'd0;
    restart();
    step(1);
    tcnt = 0; zc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (to_flag) tcnt++;
      if (tmr == 8'd0) zc++;
    end
    chk("tp0_to_cnt", tcnt, 10);
    chk("tp0_zero", zc, 10);

    // live period lowered below tmr: counts to all-ones, wraps, then honours new period
    period = 8'd20;
    restart();
    step(15);
    chk("tlp_tmr15", tmr, 15);
    period = 8'd10;
    first = -1;
    for (int i = 1; i <= 260; i++) begin
      step(1);
      if (i == 241) chk("tlp_natural_wrap", tmr, 0);
      if (to_flag && first < 0) first = i;
    end
    chk("tlp_to_at", first, 252);

    // 5: capture
    tmr_en = 1'b0;
    cp_event = 2'b01; cp_en = 1'b1;
    ctr_run = 1'b1;
    step(2);
    wait_cp(ok);
    chk("t5_first_seen", ok, 1);
    for (int k = 0; k < 3; k++) begin
      wait_cp(ok);
      chk("t5_rise_seen", ok, 1);
      chk_rng("t5_rise_count", cp_count, 18, 19);
    end
    cp_event = 2'b11;
    wait_cp(ok);
    wait_cp(ok);
    for (int k = 0; k < 3; k++) begin
      wait_cp(ok);
      chk("t5_both_seen", ok, 1);
      chk_rng("t5_both_count", cp_count, 9, 10);
    end
    ctr_man = ctr_auto;
    ctr_run = 1'b0;
    step(6);
    ctr_man = ~ctr_man;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (cp_flag) cnt++;
    end
    chk("t5_manual_edge", cnt, 1);
    step(3);
    ctr_man = ~ctr_man;
    step(2);
    cp_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (cp_flag) cnt++;
    end
    chk("t5_drop_ignored", cnt, 0);

    // 6: async reset mid-run, then en=0
    mode = 2'b00; period = 8'd20; pwm_en = 4'hF; pwm_pol = 4'b0000;
    cmp = {8'd5, 8'd12, 8'd0, 8'd15};
    cp_en = 1'b1;
    restart();
    step(7);
    chk("t6_tmr7", tmr, 7);
    chk("t6_pwm_high", pwm_out[0], 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_tmr", tmr, 0);
    chk("t6_rst_pwm", pwm_out, 0);
    chk("t6_rst_match", match_flag, 0);
    chk("t6_rst_cp_count", cp_count, 0);
    step(1);
    rst = 1'b0;
    step(5);
    pwm_pol = 4'b0101;
    en = 1'b0;
    step(1);
    chk("t6_en_tmr", tmr, 0);
    chk("t6_en_pwm", pwm_out, 4'b0101);
    chk("t6_en_to", to_flag, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
